// File: rtl/tpu_dma64_pkg.sv
// Shared types and constants for the 64-bit DMA memory responder.
package tpu_dma64_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_e;

  // Only 64-bit beats are natively supported
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;
  localparam int         DMA_DATA_W  = 64;

  // True when a request advertises a beat size other than 64 bits
  function automatic logic size_is_bad(input logic [2:0] size);
    return size != DMA_SIZE_64;
  endfunction

endpackage

// File: rtl/tpu_dma64_mem.sv
// Word-addressed storage: one write port, two combinational read ports.
// The array is deliberately not reset so preloaded contents survive rst.
module tpu_dma64_mem
  import tpu_dma64_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DMA_DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]         i_dma_raddr,
  output logic [DMA_DATA_W-1:0] o_dma_rdata,
  input  logic [AW-1:0]         i_host_raddr,
  output logic [DMA_DATA_W-1:0] o_host_rdata
);

  logic [DMA_DATA_W-1:0] r_mem [MEM_WORDS];

  // Single shared write port (DMA or host, arbitrated by the caller)
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_dma_rdata  = r_mem[i_dma_raddr];
  assign o_host_rdata = r_mem[i_host_raddr];

endmodule

// File: rtl/tpu_dma64_mem_responder.sv
// Memory-side responder for the 64-bit DMA interface: serves read bursts
// from local memory and absorbs write bursts into it; host backdoor port.
module tpu_dma64_mem_responder
  import tpu_dma64_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  // read control
  input  logic                  i_dma_read_ctrl_valid,
  output logic                  o_dma_read_ctrl_ready,
  input  logic [31:0]           i_dma_read_ctrl_data_index,
  input  logic [31:0]           i_dma_read_ctrl_data_length,
  input  logic [2:0]            i_dma_read_ctrl_data_size,
  input  logic [4:0]            i_dma_read_ctrl_data_user,
  // read data stream
  output logic                  o_dma_read_chnl_valid,
  output logic [DMA_DATA_W-1:0] o_dma_read_chnl_data,
  input  logic                  i_dma_read_chnl_ready,
  // write control
  input  logic                  i_dma_write_ctrl_valid,
  output logic                  o_dma_write_ctrl_ready,
  input  logic [31:0]           i_dma_write_ctrl_data_index,
  input  logic [31:0]           i_dma_write_ctrl_data_length,
  input  logic [2:0]            i_dma_write_ctrl_data_size,
  input  logic [4:0]            i_dma_write_ctrl_data_user,
  // write data stream
  input  logic                  i_dma_write_chnl_valid,
  input  logic [DMA_DATA_W-1:0] i_dma_write_chnl_data,
  output logic                  o_dma_write_chnl_ready,
  // host backdoor
  input  logic                  i_host_we,
  input  logic [AW-1:0]         i_host_addr,
  input  logic [DMA_DATA_W-1:0] i_host_wdata,
  output logic [DMA_DATA_W-1:0] o_host_rdata,
  // status
  output logic                  o_busy,
  output logic                  o_size_err,
  output logic [31:0]           o_debug
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  dma_state_e            r_state;
  logic [AW-1:0]         r_addr;
  logic [31:0]           r_len;
  logic [31:0]           r_beat;
  logic                  r_rd_valid;
  logic [DMA_DATA_W-1:0] r_rd_data;
  logic                  r_wr_ready;
  logic                  r_size_err;

  logic                  w_idle;
  logic                  w_rd_ctrl_hs;
  logic                  w_wr_ctrl_hs;
  logic                  w_rd_beat;
  logic                  w_wr_beat;
  logic                  w_last;
  logic [AW-1:0]         w_dma_raddr;
  logic [DMA_DATA_W-1:0] w_dma_rdata;
  logic                  w_mem_we;
  logic [AW-1:0]         w_mem_waddr;
  logic [DMA_DATA_W-1:0] w_mem_wdata;
  logic                  w_unused;

  assign w_idle       = (r_state == IDLE);
  // Read wins a simultaneous request, so write ready yields to read valid
  assign o_dma_read_ctrl_ready  = w_idle;
  assign o_dma_write_ctrl_ready = w_idle && !i_dma_read_ctrl_valid;
  assign w_rd_ctrl_hs = i_dma_read_ctrl_valid && o_dma_read_ctrl_ready;
  assign w_wr_ctrl_hs = i_dma_write_ctrl_valid && o_dma_write_ctrl_ready;

  assign w_rd_beat = r_rd_valid && i_dma_read_chnl_ready;
  assign w_wr_beat = r_wr_ready && i_dma_write_chnl_valid;
  assign w_last    = ((r_beat + 32'd1) == r_len);

  // Before the first beat is loaded r_addr is the word to fetch; afterwards it
  // names the word on the bus, so prefetch the next one for a zero-bubble stream.
  assign w_dma_raddr = r_rd_valid ? (r_addr + ADDR_ONE) : r_addr;

  // DMA writes only occur in WR, host writes only in IDLE: never both at once
  assign w_mem_we    = w_wr_beat || (w_idle && i_host_we);
  assign w_mem_waddr = w_wr_beat ? r_addr : i_host_addr;
  assign w_mem_wdata = w_wr_beat ? i_dma_write_chnl_data : i_host_wdata;

  tpu_dma64_mem #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk          (clk),
    .i_we         (w_mem_we),
    .i_waddr      (w_mem_waddr),
    .i_wdata      (w_mem_wdata),
    .i_dma_raddr  (w_dma_raddr),
    .o_dma_rdata  (w_dma_rdata),
    .i_host_raddr (i_host_addr),
    .o_host_rdata (o_host_rdata)
  );

  // Request acceptance, burst sequencing and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_wr_ready <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_ctrl_hs) begin
            r_addr <= i_dma_read_ctrl_data_index[AW-1:0];
            r_len  <= i_dma_read_ctrl_data_length;
            r_beat <= '0;
            if (size_is_bad(i_dma_read_ctrl_data_size)) begin
              r_size_err <= 1'b1;
            end
            if (i_dma_read_ctrl_data_length != 32'd0) begin
              r_state <= RD;
            end
          end else if (w_wr_ctrl_hs) begin
            r_addr <= i_dma_write_ctrl_data_index[AW-1:0];
            r_len  <= i_dma_write_ctrl_data_length;
            r_beat <= '0;
            if (size_is_bad(i_dma_write_ctrl_data_size)) begin
              r_size_err <= 1'b1;
            end
            if (i_dma_write_ctrl_data_length != 32'd0) begin
              r_state    <= WR;
              r_wr_ready <= 1'b1;
            end
          end
        end
        RD: begin
          if (!r_rd_valid) begin
            r_rd_data  <= w_dma_rdata;
            r_rd_valid <= 1'b1;
          end else if (w_rd_beat) begin
            r_beat <= r_beat + 32'd1;
            if (w_last) begin
              r_rd_valid <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_addr    <= r_addr + ADDR_ONE;
              r_rd_data <= w_dma_rdata;
            end
          end
        end
        WR: begin
          if (w_wr_beat) begin
            r_addr <= r_addr + ADDR_ONE;
            r_beat <= r_beat + 32'd1;
            if (w_last) begin
              r_wr_ready <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_dma_read_chnl_valid  = r_rd_valid;
  assign o_dma_read_chnl_data   = r_rd_data;
  assign o_dma_write_chnl_ready = r_wr_ready;
  assign o_busy                 = !w_idle;
  assign o_size_err             = r_size_err;
  assign o_debug                = {28'd0, r_state, 1'b0, r_size_err};

  // User tags and index bits above the memory range carry no meaning here
  assign w_unused = ^{i_dma_read_ctrl_data_user, i_dma_write_ctrl_data_user,
                      i_dma_read_ctrl_data_index[31:AW],
                      i_dma_write_ctrl_data_index[31:AW]};

endmodule

// File: doc/tpu_dma64_mem_responder.md
# tpu_dma64_mem_responder

Memory-side responder for the 64-bit ESP DMA interface used by the TPU accelerator tiles. It accepts read and write control requests from an accelerator, streams read data from a local word-addressed memory, and absorbs write data into that memory. It is used in unit-level benches and standalone bring-up in place of the NoC/DMA engine. A host port preloads and inspects the memory.

## Interface
- MEM_WORDS, 1024: memory depth in 64-bit words; power of two; address width AW = clog2(MEM_WORDS).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- dma_read_ctrl_valid / dma_read_ctrl_ready  in / out  1 / 1  read request handshake.
- dma_read_ctrl_data_index / dma_read_ctrl_data_length  in  32 / 32  start word and beat count.
- dma_read_ctrl_data_size / dma_read_ctrl_data_user  in  3 / 5  beat size code and user tag; user is ignored.
- dma_read_chnl_valid / dma_read_chnl_data / dma_read_chnl_ready  out / out / in  1 / 64 / 1  read data stream.
- dma_write_ctrl_valid / ready / data_index / data_length / data_size / data_user  have the same widths as the read ctrl ports, with ready as the output.
- dma_write_chnl_valid / dma_write_chnl_data / dma_write_chnl_ready  in / in / out  1 / 64 / 1  write data stream.
- host_we / host_addr / host_wdata / host_rdata  in / in / in / out  1 / AW / 64 / 64  backdoor access; read is combinational.
- busy  out  1  high in any state other than IDLE.
- size_err  out  1  sticky; set when a request carries a size other than 3'b011.
- debug  out  32  {28'd0, state[1:0], 1'b0, size_err}.

## Operation
- FSM has three states: IDLE, RD, WR. Reset puts it in IDLE.
- IDLE:
  - Both ctrl ready outputs are high.
  - If both ctrl valids are high in the same cycle, read wins and write ready drops low for that cycle.
  - On a handshake, the block latches index[AW-1:0], length, and clears the beat count.
- Length 0: the request is accepted, no beats are issued, and the FSM stays in IDLE.
- RD:
  - The data register loads mem[(idx+beat) mod MEM_WORDS] and chnl_valid goes high.
  - On each valid&ready, beat is incremented and the next word loads in the same edge.
  - After the last beat's handshake, chnl_valid drops low and the FSM returns to IDLE.
  - While ready is low, data is held stable.
- WR:
  - write_chnl_ready is high.
  - Each valid&ready writes data to mem[(idx+beat) mod MEM_WORDS].
  - After `length` beats, the FSM returns to IDLE.
- Address arithmetic is modulo MEM_WORDS. Index bits above AW are ignored, so a burst crossing the top of memory wraps to word 0.
- size_err:
  - Set on any accepted request whose size ≠ 3'b011. The transfer still proceeds as 64-bit beats.
  - Cleared only by rst.
- Host port:
  - host_we is honoured only in IDLE; otherwise it is dropped.
  - In the same cycle as an accepted ctrl request, the host write still commits.
- Reset mid-burst: the FSM returns to IDLE and all valid/ready outputs take their reset values. Memory contents are not reset; the partial burst's writes remain.

## Timing
- Reset values:
  - Both ctrl readies = 1, since the FSM resets to IDLE.
  - read_chnl_valid = 0, read_chnl_data = 0, write_chnl_ready = 0.
  - busy = 0, size_err = 0.
- Read latency: ctrl handshake at edge N; beat 0 valid after edge N+1.
- With ready held high, the read stream sustains one beat per cycle.
- Write: ctrl handshake at edge N; write_chnl_ready is high from N+1, one beat per cycle.
- Ctrl ready is low for the whole burst and returns high the cycle after the final beat handshake. There is one bubble between back-to-back bursts.
- A write is visible on host_rdata the cycle after its handshake edge.

## Structure
- Package tpu_dma64_pkg holds:
  - the state enum {IDLE, RD, WR}
  - DMA_SIZE_64 = 3'b011
  - DMA_DATA_W = 64
- Sub-module tpu_dma64_mem: register array with one write port muxed between DMA and host, one combinational read port for DMA, and one for the host. No reset on the array.

## Test plan
- Preload mem[0..3] = 0xA0..0xA3 via host; read index 0, length 4, ready high → beats 0xA0..0xA3 on 4 consecutive cycles, first one cycle after the ctrl handshake; busy falls after the last beat.
- Write index 1020, length 8, data 0x100..0x107 → host reads words 1020..1023 = 0x100..0x103 and words 0..3 = 0x104..0x107 (wrap).
- Read length 3 with chnl_ready toggled 1,0,0,1,… → each beat held stable while ready is low; exactly 3 handshakes, no duplicates.
- Read and write ctrl valid in the same cycle → read accepted first; write accepted one cycle after the read's last beat.
- Request with size 3'b010, length 0 → accepted, FSM stays IDLE, size_err = 1 until rst.
- Assert rst mid-way through an 8-beat write → after 4 beats: outputs take reset values, FSM in IDLE, words 0–3 written, words 4–7 unchanged.
